// File: rtl/hbm_model_pkg.sv
// Types and helpers shared by the HBM read-side channel model.
package hbm_model_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } rd_state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Byte address to beat-word index; low bits inside one beat are dropped.
  function automatic logic [63:0] word_index(input logic [63:0] byte_addr,
                                             input int unsigned data_w);
    return byte_addr >> $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/hbm_rd_channel.sv
// One HBM read channel: AR capture, fixed latency, burst return from a private word memory.
// Optional HBM_RD_STALL_EN inserts a one-cycle rvalid bubble every STALL_PERIOD accepted beats.
module hbm_rd_channel
  import hbm_model_pkg::*;
#(
  parameter int DATA_W       = 512,
  parameter int ADDR_W       = 33,
  parameter int LAT          = 8,
  parameter int MEM_WORDS    = 256,
  parameter int STALL_PERIOD = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            araddr,
  input  logic [7:0]                   arlen,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [DATA_W-1:0]            rdata,
  output logic                         rvalid,
  output logic                         rlast,
  input  logic                         rready,
  input  logic                         init_we,
  input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
  input  logic [DATA_W-1:0]            init_data
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  if (LAT < 1) begin : g_lat_check
    $error("LAT must be >= 1");
  end
  if (STALL_PERIOD < 1) begin : g_stall_check
    $error("STALL_PERIOD must be >= 1");
  end
  if ((1 << IDX_W) != MEM_WORDS) begin : g_mem_check
    $error("MEM_WORDS must be a power of two");
  end

  rd_state_t         state;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        len;
  logic [7:0]        beat;
  logic [CNT_W-1:0]  cnt;
  logic              bubble;
  logic              present;
  logic              ar_fire;
  logic              r_fire;
  logic [DATA_W-1:0] mem [MEM_WORDS];

  // Outputs are forced quiet while rst is high, even before the reset edge lands.
  assign present = (state == BURST) && !rst;
  assign arready = (state == IDLE) && !rst;
  assign rvalid  = present && !bubble;
  assign rlast   = present && (beat == len);
  assign rdata   = present ? mem[idx] : '0;
  assign ar_fire = arvalid && arready;
  assign r_fire  = rvalid && rready;

  always_ff @(posedge clk) begin
    if (init_we) mem[init_addr] <= init_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      len   <= '0;
      beat  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ar_fire) begin
            idx   <= IDX_W'(word_index(64'(araddr), DATA_W));
            len   <= arlen;
            beat  <= '0;
            cnt   <= CNT_W'(LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) state <= BURST;
          else           cnt   <= cnt - 1'b1;
        end
        BURST: begin
          if (r_fire) begin
            beat <= beat + 8'd1;
            idx  <= idx + 1'b1;
            if (rlast) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HBM_RD_STALL_EN
  localparam int SC_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

  logic [SC_W-1:0] stall_cnt;

  // No bubble follows the final beat, so the channel is back in IDLE right after rlast.
  always_ff @(posedge clk) begin
    if (rst || ar_fire) begin
      stall_cnt <= '0;
      bubble    <= 1'b0;
    end else begin
      bubble <= 1'b0;
      if (r_fire && !rlast) begin
        if (stall_cnt == SC_W'(STALL_PERIOD - 1)) begin
          stall_cnt <= '0;
          bubble    <= 1'b1;
        end else begin
          stall_cnt <= stall_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign bubble = 1'b0;
`endif

endmodule

// File: rtl/hbm_rd_channel_model.sv
// Multi-channel AXI4 read responder emulating the HBM read ports; one hbm_rd_channel per channel.
// Optional HBM_RD_STALL_EN enables periodic rvalid bubbles inside bursts.
module hbm_rd_channel_model
  import hbm_model_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int DATA_W       = 512,
  parameter int ADDR_W       = 33,
  parameter int LAT          = 8,
  parameter int MEM_WORDS    = 256,
  parameter int STALL_PERIOD = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_CH*ADDR_W-1:0]                     araddr_HBM,
  input  logic [NUM_CH*8-1:0]                          arlen_HBM,
  input  logic [NUM_CH-1:0]                            arvalid_HBM,
  output logic [NUM_CH-1:0]                            arready_HBM,
  output logic [NUM_CH*DATA_W-1:0]                     rdata_HBM,
  output logic [NUM_CH-1:0]                            rvalid_HBM,
  output logic [NUM_CH-1:0]                            rlast_HBM,
  output logic [NUM_CH*2-1:0]                          rresp_HBM,
  input  logic [NUM_CH-1:0]                            rready_HBM,
  input  logic                                         init_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] init_ch,
  input  logic [$clog2(MEM_WORDS)-1:0]                 init_addr,
  input  logic [DATA_W-1:0]                            init_data
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  assign rresp_HBM = {NUM_CH{AXI_RESP_OKAY}};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_en;

    // Selects beyond NUM_CH match no instance and are dropped.
    assign wr_en = init_we && (init_ch == CH_W'(i));

    hbm_rd_channel #(
      .DATA_W       (DATA_W),
      .ADDR_W       (ADDR_W),
      .LAT          (LAT),
      .MEM_WORDS    (MEM_WORDS),
      .STALL_PERIOD (STALL_PERIOD)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .araddr    (araddr_HBM[i*ADDR_W +: ADDR_W]),
      .arlen     (arlen_HBM[i*8 +: 8]),
      .arvalid   (arvalid_HBM[i]),
      .arready   (arready_HBM[i]),
      .rdata     (rdata_HBM[i*DATA_W +: DATA_W]),
      .rvalid    (rvalid_HBM[i]),
      .rlast     (rlast_HBM[i]),
      .rready    (rready_HBM[i]),
      .init_we   (wr_en),
      .init_addr (init_addr),
      .init_data (init_data)
    );
  end

endmodule
